// File: rtl/video_mode_ctrl_if.sv
// Bundle of control and timing signals between the mode sequencer and its user.
// A preset change is requested with a single-cycle I_mode_req pulse carrying I_mode_sel.
// The pulse is accepted only while O_busy is 0. Each accepted request is answered by exactly one
// single-cycle O_mode_ack. A pulse that arrives while O_busy is 1 is dropped without an ack.
interface video_mode_ctrl_if;
  logic        I_frame_start;
  logic        I_mode_req;
  logic [1:0]  I_mode_sel;
  logic        O_mode_ack;
  logic        O_busy;
  logic        O_gen_rst_n;
  logic [11:0] O_h_total;
  logic [11:0] O_h_sync;
  logic [11:0] O_h_bporch;
  logic [11:0] O_h_res;
  logic [11:0] O_v_total;
  logic [11:0] O_v_sync;
  logic [11:0] O_v_bporch;
  logic [11:0] O_v_res;
  logic        O_hs_pol;
  logic        O_vs_pol;
  logic [1:0]  O_mode;
  logic        I_pattern_next;
  logic        I_auto_en;
  logic [2:0]  O_pattern;
  logic [1:0]  O_dbg_state;

  modport master (
    output I_frame_start, I_mode_req, I_mode_sel, I_pattern_next, I_auto_en,
    input  O_mode_ack, O_busy, O_gen_rst_n,
    input  O_h_total, O_h_sync, O_h_bporch, O_h_res,
    input  O_v_total, O_v_sync, O_v_bporch, O_v_res,
    input  O_hs_pol, O_vs_pol, O_mode, O_pattern, O_dbg_state
  );

  modport slave (
    input  I_frame_start, I_mode_req, I_mode_sel, I_pattern_next, I_auto_en,
    output O_mode_ack, O_busy, O_gen_rst_n,
    output O_h_total, O_h_sync, O_h_bporch, O_h_res,
    output O_v_total, O_v_sync, O_v_bporch, O_v_res,
    output O_hs_pol, O_vs_pol, O_mode, O_pattern, O_dbg_state
  );
endinterface

// File: rtl/video_mode_ctrl.sv
// Video timing preset sequencer and test-pattern selector for the HDMI pattern generator.
// Preset switches happen at a frame boundary while the generator is held in reset.
module video_mode_ctrl #(
  parameter int HOLD_CYCLES  = 16,
  parameter int WAIT_TIMEOUT = 2097152,
  parameter int AUTO_FRAMES  = 120
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  video_mode_ctrl_if.slave bus
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int AW = (AUTO_FRAMES  > 1) ? $clog2(AUTO_FRAMES)  : 1;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(WAIT_TIMEOUT - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  function automatic timing_t preset(input logic [1:0] idx);
    timing_t t;
    case (idx)
      2'd0:    t = {12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0};
      2'd1:    t = {12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
      2'd2:    t = {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0};
      default: t = {12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};
    endcase
    return t;
  endfunction

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    sel_q;
  logic [1:0]    mode_q;
  timing_t       timing_q;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          gen_rst_n_q;
  logic          ack_q;
  logic          req_new;
  logic          req_same;
  logic          hold_done;

  logic [AW-1:0] auto_cnt;
  logic          pend_q;
  logic [1:0]    pat_q;
  logic          frame_ok;
  logic          auto_hit;

  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_new   = 1'b0;
    req_same  = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      IDLE: begin
        req_same = bus.I_mode_req && (bus.I_mode_sel == mode_q);
        req_new  = bus.I_mode_req && (bus.I_mode_sel != mode_q);
        if (req_new) state_d = WAIT_FS;
      end
      WAIT_FS: begin
        if (bus.I_frame_start || (tmo_cnt == TMO_LAST)) state_d = HOLD;
      end
      HOLD: begin
        hold_done = (hold_cnt == HOLD_LAST);
        if (hold_done) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The new preset is loaded one cycle before the hold ends so it is already
  // stable during the last cycle the generator spends in reset.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      sel_q       <= 2'd0;
      mode_q      <= 2'd0;
      timing_q    <= preset(2'd0);
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      gen_rst_n_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      if (req_new) sel_q <= bus.I_mode_sel;
      hold_cnt    <= (state_q == HOLD)    ? hold_cnt + 1'b1 : '0;
      tmo_cnt     <= (state_q == WAIT_FS) ? tmo_cnt + 1'b1  : '0;
      gen_rst_n_q <= (state_d != HOLD);
      ack_q       <= req_same || hold_done;
      if ((state_q == HOLD) && (hold_cnt == HOLD_LOAD)) begin
        timing_q <= preset(sel_q);
        mode_q   <= sel_q;
      end
    end
  end

  // Pattern advances are only applied at a frame start seen while the generator runs.
  assign frame_ok = bus.I_frame_start && gen_rst_n_q;
  assign auto_hit = bus.I_auto_en && bus.I_frame_start && (auto_cnt == AUTO_LAST);

  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      pat_q    <= 2'd0;
      pend_q   <= 1'b0;
      auto_cnt <= '0;
    end else begin
      if (frame_ok && pend_q) pat_q <= pat_q + 1'b1;
      if (bus.I_pattern_next || auto_hit) pend_q <= 1'b1;
      else if (frame_ok)                  pend_q <= 1'b0;
      if (!bus.I_auto_en || bus.I_pattern_next || auto_hit) auto_cnt <= '0;
      else if (bus.I_frame_start)                          auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign bus.O_mode_ack  = ack_q;
  assign bus.O_busy      = (state_q != IDLE);
  assign bus.O_gen_rst_n = gen_rst_n_q;
  assign bus.O_h_total   = timing_q.h_total;
  assign bus.O_h_sync    = timing_q.h_sync;
  assign bus.O_h_bporch  = timing_q.h_bporch;
  assign bus.O_h_res     = timing_q.h_res;
  assign bus.O_v_total   = timing_q.v_total;
  assign bus.O_v_sync    = timing_q.v_sync;
  assign bus.O_v_bporch  = timing_q.v_bporch;
  assign bus.O_v_res     = timing_q.v_res;
  assign bus.O_hs_pol    = timing_q.hs_pol;
  assign bus.O_vs_pol    = timing_q.vs_pol;
  assign bus.O_mode      = mode_q;
  assign bus.O_pattern   = {1'b0, pat_q};
  assign bus.O_dbg_state = state_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized self-checking bench for video_mode_ctrl: preset switching timeline,
// same-preset and dropped requests, wait timeout, pattern sequencing and reset mid-hold.
module tb_video_mode_ctrl;
  localparam int HOLD = 16;
  localparam int TMO  = 64;
  localparam int AUTO = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  video_mode_ctrl_if bus();

  video_mode_ctrl #(
    .HOLD_CYCLES (HOLD),
    .WAIT_TIMEOUT(TMO),
    .AUTO_FRAMES (AUTO)
  ) dut (
    .I_pxl_clk(clk),
    .I_rst_n  (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cur_mode = 0;
  int cur_pat  = 0;
  bit pending  = 0;
  int frames   = 0;
  logic [2:0] exp_q[$];

  // Standard timing presets: h_total,h_sync,h_bporch,h_res,v_total,v_sync,v_bporch,v_res,hs_pol,vs_pol
  int tab [4][10] = '{
    '{800,  96,  48,  640,  525, 2, 33, 480, 0, 0},
    '{1056, 128, 88,  800,  628, 4, 23, 600, 1, 1},
    '{1344, 136, 160, 1024, 806, 6, 29, 768, 0, 0},
    '{1650, 40,  220, 1280, 750, 5, 20, 720, 1, 1}
  };

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [97:0] timing_of(input int m);
    timing_of = {12'(tab[m][0]), 12'(tab[m][1]), 12'(tab[m][2]), 12'(tab[m][3]),
                 12'(tab[m][4]), 12'(tab[m][5]), 12'(tab[m][6]), 12'(tab[m][7]),
                 1'(tab[m][8]), 1'(tab[m][9])};
  endfunction

  function automatic logic [127:0] exp_vec(input bit b, input bit g, input bit a, input int m, input int p);
    exp_vec = {22'd0, 3'(p), b, g, a, 2'(m), timing_of(m)};
  endfunction

  function automatic logic [127:0] obs_vec();
    obs_vec = {22'd0, bus.O_pattern, bus.O_busy, bus.O_gen_rst_n, bus.O_mode_ack, bus.O_mode,
               bus.O_h_total, bus.O_h_sync, bus.O_h_bporch, bus.O_h_res,
               bus.O_v_total, bus.O_v_sync, bus.O_v_bporch, bus.O_v_res,
               bus.O_hs_pol, bus.O_vs_pol};
  endfunction

  task automatic clear_inputs();
    bus.I_frame_start  = 1'b0;
    bus.I_mode_req     = 1'b0;
    bus.I_mode_sel     = 2'd0;
    bus.I_pattern_next = 1'b0;
    bus.I_auto_en      = 1'b0;
  endtask

  // rel counts cycles from the request; fr is the cycle the hold is triggered.
  task automatic do_switch(input int sel, input int gap, input bit use_fs, input bit extra, input string nm);
    bit diff;
    int fr, last, xr;
    diff = (sel != cur_mode);
    fr   = use_fs ? gap : TMO;
    last = diff ? fr + HOLD + 3 : 3;
    xr   = (extra && diff) ? int'($urandom_range(1, fr + HOLD + 1)) : -1;
    for (int rel = 0; rel <= last; rel++) begin
      bit b, g, a;
      int m;
      @(posedge clk); #1;
      bus.I_mode_req    = (rel == 0) || (rel == xr);
      bus.I_mode_sel    = (rel == 0) ? 2'(sel) : 2'(sel ^ 1);
      bus.I_frame_start = use_fs && (rel == gap);
      @(negedge clk);
      if (diff) begin
        b = (rel >= 1) && (rel <= fr + HOLD + 1);
        g = !((rel >= fr + 1) && (rel <= fr + HOLD));
        a = (rel == fr + HOLD + 1);
        m = (rel >= fr + HOLD) ? sel : cur_mode;
      end else begin
        b = 1'b0;
        g = 1'b1;
        a = (rel == 1);
        m = cur_mode;
      end
      check($sformatf("%s rel%0d", nm, rel), obs_vec(), exp_vec(b, g, a, m, cur_pat));
    end
    clear_inputs();
    cur_mode = sel;
  endtask

  task automatic pattern_run(input int ncyc);
    exp_q.delete();
    exp_q.push_back(3'(cur_pat));
    for (int k = 0; k < ncyc; k++) begin
      bit fs, nxt, aut;
      logic [2:0] e;
      if (k < ncyc - 20) begin
        fs  = ($urandom_range(0, 4) == 0);
        nxt = ($urandom_range(0, 9) == 0);
        aut = ((k / 50) % 3) != 0;
      end else begin
        fs  = (k == ncyc - 10);
        nxt = 1'b0;
        aut = 1'b0;
      end
      @(posedge clk); #1;
      bus.I_frame_start  = fs;
      bus.I_pattern_next = nxt;
      bus.I_auto_en      = aut;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("pat k%0d", k), obs_vec(), exp_vec(1'b0, 1'b1, 1'b0, cur_mode, int'(e)));
      // Reference: one advance per frame start that follows any request.
      if (fs && pending) begin
        cur_pat = (cur_pat + 1) % 4;
        pending = 1'b0;
      end
      if (nxt) begin
        pending = 1'b1;
        frames  = 0;
      end else if (!aut) begin
        frames = 0;
      end else if (fs) begin
        frames++;
        if (frames == AUTO) begin
          pending = 1'b1;
          frames  = 0;
        end
      end
      exp_q.push_back(3'(cur_pat));
    end
    exp_q.delete();
    clear_inputs();
  endtask

  task automatic reset_mid_hold();
    int sel = (cur_mode + 1) % 4;
    int r   = 3 + 6;
    for (int rel = 0; rel <= r + 20; rel++) begin
      bit b, g;
      int m, p;
      @(posedge clk); #1;
      rst_n             = (rel != r);
      bus.I_mode_req    = (rel == 0);
      bus.I_mode_sel    = 2'(sel);
      bus.I_frame_start = (rel == 3);
      @(negedge clk);
      if (rel <= r) begin
        b = (rel >= 1);
        g = !(rel >= 4);
        m = cur_mode;
        p = cur_pat;
      end else begin
        b = 1'b0;
        g = (rel >= r + 2);
        m = 0;
        p = 0;
      end
      check($sformatf("rst rel%0d", rel), obs_vec(), exp_vec(b, g, 1'b0, m, p));
    end
    clear_inputs();
    cur_mode = 0;
    cur_pat  = 0;
    pending  = 1'b0;
    frames   = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release", obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), obs_vec(), exp_vec(1'b0, 1'b1, 1'b0, 0, 0));
    end

    do_switch(0, 1, 1'b0, 1'b0, "same0");
    do_switch(3, 50, 1'b1, 1'b1, "to3");
    do_switch(3, 1, 1'b0, 1'b0, "same3");
    do_switch(1, 1, 1'b0, 1'b1, "tmo1");
    for (int i = 0; i < 6; i++) begin
      int s, g;
      bit u;
      s = $urandom_range(0, 3);
      g = $urandom_range(1, 60);
      u = ($urandom_range(0, 3) != 0);
      do_switch(s, g, u, 1'b1, $sformatf("rnd%0d", i));
    end

    pattern_run(400);
    reset_mid_hold();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
